// File: rtl/serial_tx_pkg.sv
// Shared types and line levels for the tick-paced serial transmitter.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/tick_edge_sync.sv
// Brings an asynchronous bit-rate square wave into clk and emits one
// clk-wide pulse per rising edge of it.
module tick_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic tick_clk,
    output logic bit_tick
);

    logic sync1;
    logic sync2;
    logic sync3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= tick_clk;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign bit_tick = sync2 & ~sync3;

endmodule

// File: rtl/serial_tx_tick.sv
// Serial frame transmitter paced by an external bit-rate tick:
// start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
module serial_tx_tick
    import serial_tx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0,
    parameter int STOP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_clk,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              parity;
    logic              bit_tick;

    tick_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .tick_clk (tick_clk),
        .bit_tick (bit_tick)
    );

    assign tx_busy  = (state != ST_IDLE);
    assign tx_ready = ~tx_busy;

    // tx_out is only ever loaded on the edge that consumes bit_tick
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            tx_out   <= IDLE_LEVEL;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            parity   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        shreg  <= tx_data;
                        parity <= ^tx_data;
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bit_tick) begin
                        state  <= ST_START;
                        tx_out <= START_LEVEL;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        state   <= ST_DATA;
                        tx_out  <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state  <= ST_PARITY;
                                tx_out <= parity;
                            end else begin
                                state    <= ST_STOP;
                                tx_out   <= IDLE_LEVEL;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            tx_out <= shreg[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        state    <= ST_STOP;
                        tx_out   <= IDLE_LEVEL;
                        stop_cnt <= 1'b0;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            state    <= ST_IDLE;
                            tx_done  <= 1'b1;
                            stop_cnt <= 1'b0;
                            bit_cnt  <= '0;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_out <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_tick.sv
// Scoreboard bench: stimulus queues expected frames, a tick-rate monitor decodes the line.
module tb_serial_tx_tick;

    localparam int DW = 8;
    localparam int PE = 1;
    localparam int SB = 2;
    localparam int FL = 1 + DW + PE + SB;

    logic          clk;
    logic          rst;
    logic          tick_clk;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_out;
    logic          tx_busy;
    logic          tx_done;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    int epoch = 0;
    bit freeze = 0;

    logic [FL-1:0] exp_q[$];

    serial_tx_tick #(
        .DATA_W    (DW),
        .PARITY_EN (PE),
        .STOP_BITS (SB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_clk (tick_clk),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // 16 clk per bit; toggles land on clk falling edges
    initial begin
        tick_clk = 0;
        forever begin
            #80;
            if (!freeze) tick_clk = ~tick_clk;
        end
    end

    function automatic logic [FL-1:0] frame_of(input logic [DW-1:0] d);
        logic [FL-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DW; i++) f[1+i] = d[i];
        if (PE != 0) f[1+DW] = ^d;
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d);
        exp_q.push_back(frame_of(d));
        exp_frames++;
    endtask

    // monitor: one line sample per tick period, taken at each tick_clk rise
    bit            in_frame = 0;
    int            idx = 0;
    int            gap = 0;
    int            last_gap = -1;
    int            frames_done = 0;
    int            seen = 0;
    logic [FL-1:0] cur;
    logic [FL-1:0] cur_exp;

    always @(posedge tick_clk) begin
        if (epoch != seen) begin
            seen = epoch;
            in_frame = 0;
            exp_q.delete();
            gap = 0;
        end
        if (!in_frame) begin
            if (tx_out === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_start got start want idle");
                end else begin
                    cur_exp = exp_q.pop_front();
                    cur = '1;
                    cur[0] = 1'b0;
                    idx = 1;
                    in_frame = 1;
                    last_gap = gap;
                    gap = 0;
                end
            end else begin
                gap++;
            end
        end else begin
            cur[idx] = tx_out;
            idx++;
            if (idx == FL) begin
                chk("frame", 32'(cur), 32'(cur_exp));
                frames_done++;
                in_frame = 0;
            end
        end
    end

    int done_cnt = 0;
    int bad_inv = 0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt++;
        if (tx_ready === tx_busy) bad_inv++;
    end

    task automatic send(input logic [DW-1:0] d, input bit keep);
        int n;
        n = 0;
        @(negedge clk);
        tx_data = d;
        tx_valid = 1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            chk("send_timeout", 32'(n), 0);
            tx_valid = 0;
        end else begin
            @(posedge clk);
            push_exp(d);
            #1;
            if (!keep) tx_valid = 0;
            tx_data = DW'($urandom);
        end
    endtask

    task automatic wait_frames(input int n);
        int k;
        k = 0;
        while (frames_done < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (frames_done < n) chk("frame_timeout", 32'(frames_done), 32'(n));
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (tx_out !== 1'b0 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (tx_out !== 1'b0) chk("start_timeout", 32'(tx_out), 0);
    endtask

    initial begin
        logic          ref_out;
        bit            stable;
        logic [DW-1:0] d;
        bit            keep;

        rst = 0;
        tx_valid = 0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_out", 32'(tx_out), 1);
        chk("rst_ready", 32'(tx_ready), 1);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        rst = 1;
        repeat (40) @(negedge clk);

        send(8'hA5, 0);
        wait_frames(exp_frames);

        send(8'h01, 1);
        send(8'h80, 0);
        wait_frames(exp_frames);
        chk("b2b_gap", 32'(last_gap), 1);
        repeat (40) @(negedge clk);

        @(posedge tick_clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        tx_data = 8'h69;
        tx_valid = 1;
        @(posedge clk);
        push_exp(8'h69);
        #1;
        tx_valid = 0;
        @(posedge tick_clk);
        chk("coinc_hold", 32'(tx_out), 1);
        @(posedge tick_clk);
        chk("coinc_start", 32'(tx_out), 0);
        wait_frames(exp_frames);

        send(8'h3C, 0);
        wait_start();
        repeat (4 * 16 + 4) @(negedge clk);
        chk("pre_rst_bit3", 32'(tx_out), 1);
        #2;
        rst = 0;
        epoch++;
        exp_frames--;
        #1;
        chk("abort_out", 32'(tx_out), 1);
        chk("abort_ready", 32'(tx_ready), 1);
        chk("abort_busy", 32'(tx_busy), 0);
        repeat (3) @(negedge clk);
        rst = 1;
        @(posedge tick_clk);
        @(posedge tick_clk);
        send(8'h3C, 0);
        wait_frames(exp_frames);

        send(DW'($urandom), 0);
        wait_start();
        repeat (2 * 16 + 4) @(negedge clk);
        freeze = 1;
        ref_out = tx_out;
        stable = 1;
        repeat (1000) begin
            @(negedge clk);
            if (tx_out !== ref_out || tx_busy !== 1'b1) stable = 0;
        end
        chk("freeze_hold", 32'(stable), 1);
        freeze = 0;
        wait_frames(exp_frames);

        for (int i = 0; i < 16; i++) begin
            d = DW'($urandom);
            keep = (i != 15) && ($urandom_range(0, 3) == 0);
            send(d, keep);
            if (!keep) repeat ($urandom_range(0, 300)) @(negedge clk);
        end
        wait_frames(exp_frames);
        repeat (40) @(negedge clk);

        chk("done_pulses", 32'(done_cnt), 32'(frames_done));
        chk("frames_total", 32'(frames_done), 32'(exp_frames));
        chk("ready_inv", 32'(bad_inv), 0);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
